// File: rtl/data_mem_sequencer_pkg.sv
// Shared encodings for the data-memory sequencer: load/store funct3 values,
// FSM states and fault codes reported to the core.
package data_mem_sequencer_pkg;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

endpackage

// File: rtl/data_mem_sequencer_lane_format.sv
// Combinational access formatting: byte enables, store lane replication,
// alignment/legality check and load-data extraction with extension.
module mem_lane_format
   import data_mem_sequencer_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic        bad,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      be          = 4'b0000;
      wdata_lanes = 32'h0;
      bad         = 1'b0;
      rdata_ext   = 32'h0;
      shifted     = rdata >> {addr_lo, 3'b000};
      case (funct3)
         FUNCT3_LB: begin
            be          = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {{24{shifted[7]}}, shifted[7:0]};
         end
         FUNCT3_LH: begin
            bad         = addr_lo[0];
            be          = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {{16{shifted[15]}}, shifted[15:0]};
         end
         FUNCT3_LW: begin
            bad         = |addr_lo;
            be          = 4'b1111;
            wdata_lanes = wdata;
            rdata_ext   = shifted;
         end
         // Unsigned variants only exist for loads.
         FUNCT3_LBU: begin
            bad         = we;
            be          = 4'b0001 << addr_lo;
            rdata_ext   = {24'h0, shifted[7:0]};
         end
         FUNCT3_LHU: begin
            bad         = we | addr_lo[0];
            be          = addr_lo[1] ? 4'b1100 : 4'b0011;
            rdata_ext   = {16'h0, shifted[15:0]};
         end
         default: bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_sequencer.sv
// Sequences a single core load/store onto a variable-latency data memory,
// holding the bus request until ack or timeout and reporting done/fault.
//
// state    | meaning
// ST_IDLE  | ready for a new request
// ST_ISSUE | bus request held, waiting for ack
// ST_DONE  | one-cycle success pulse
// ST_FAULT | one-cycle fault pulse (misaligned/illegal or timeout)
module data_mem_sequencer
   import data_mem_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        iCLK,
   input  logic        iRSTn,
   input  logic        iReq,
   input  logic        iWe,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddr,
   input  logic [31:0] iWData,
   output logic        oReady,
   output logic        oDone,
   output logic [1:0]  oFault,
   output logic [31:0] oRData,
   output logic        oMemReq,
   output logic        oMemWe,
   output logic [31:0] oMemAddr,
   output logic [3:0]  oMemBE,
   output logic [31:0] oMemWData,
   input  logic        iMemAck,
   input  logic [31:0] iMemRData
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_e      state_q, state_d;
   logic        req_we_q, req_we_d;
   logic [2:0]  req_funct3_q, req_funct3_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic [1:0]  fault_q, fault_d;
   logic [31:0] rdata_q, rdata_d;

   logic        idle, issue, timeout_hit;
   logic        fmt_we, fmt_bad;
   logic [2:0]  fmt_funct3;
   logic [1:0]  fmt_addr_lo;
   logic [31:0] fmt_wdata, fmt_lanes, fmt_rdata_ext;
   logic [3:0]  fmt_be;

   assign idle  = (state_q == ST_IDLE);
   assign issue = (state_q == ST_ISSUE);
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1));

   // Formatter judges the incoming request in IDLE, the latched one otherwise.
   assign fmt_we      = idle ? iWe          : req_we_q;
   assign fmt_funct3  = idle ? iFunct3      : req_funct3_q;
   assign fmt_addr_lo = idle ? iAddr[1:0]   : req_addr_q[1:0];
   assign fmt_wdata   = idle ? iWData       : req_wdata_q;

   mem_lane_format u_fmt (
      .we          (fmt_we),
      .funct3      (fmt_funct3),
      .addr_lo     (fmt_addr_lo),
      .wdata       (fmt_wdata),
      .rdata       (iMemRData),
      .be          (fmt_be),
      .wdata_lanes (fmt_lanes),
      .bad         (fmt_bad),
      .rdata_ext   (fmt_rdata_ext)
   );

   always_comb begin
      state_d      = state_q;
      req_we_d     = req_we_q;
      req_funct3_d = req_funct3_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      wait_cnt_d   = wait_cnt_q;
      fault_d      = fault_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (iReq) begin
               req_we_d     = iWe;
               req_funct3_d = iFunct3;
               req_addr_d   = iAddr;
               req_wdata_d  = iWData;
               wait_cnt_d   = '0;
               rdata_d      = 32'h0;
               if (fmt_bad) begin
                  fault_d = FAULT_MISALIGN;
                  state_d = ST_FAULT;
               end else begin
                  fault_d = FAULT_NONE;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (iMemAck) begin
               if (!req_we_q) rdata_d = fmt_rdata_ext;
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               fault_d = FAULT_TIMEOUT;
               state_d = ST_FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_DONE, ST_FAULT: begin
            wait_cnt_d = '0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q      <= ST_IDLE;
         req_we_q     <= 1'b0;
         req_funct3_q <= 3'b000;
         req_addr_q   <= 32'h0;
         req_wdata_q  <= 32'h0;
         wait_cnt_q   <= '0;
         fault_q      <= FAULT_NONE;
         rdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         req_we_q     <= req_we_d;
         req_funct3_q <= req_funct3_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         wait_cnt_q   <= wait_cnt_d;
         fault_q      <= fault_d;
         rdata_q      <= rdata_d;
      end
   end

   // Bus outputs decode straight from the state flop so reset drops them at once.
   assign oReady    = idle;
   assign oDone     = (state_q == ST_DONE) || (state_q == ST_FAULT);
   assign oFault    = oDone ? fault_q : FAULT_NONE;
   assign oRData    = rdata_q;
   assign oMemReq   = issue;
   assign oMemWe    = issue & req_we_q;
   assign oMemAddr  = issue ? {req_addr_q[31:2], 2'b00} : 32'h0;
   assign oMemBE    = issue ? fmt_be : 4'b0000;
   assign oMemWData = (issue && req_we_q) ? fmt_lanes : 32'h0;

endmodule
